// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding, entry field layout and defaults for the commit trace buffer
package trace_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, POST = 3'd2, FROZEN = 3'd3} state_t;
    localparam int TS_W_DEF = 16;
    // Entry layout, LSB first: data, rd, opc, pc, ts
    localparam int OFF_DATA = 0;
    function automatic int off_rd(int dw);
        return dw;
    endfunction
    function automatic int off_opc(int dw, int rw);
        return dw + rw;
    endfunction
    function automatic int off_pc(int dw, int rw, int ow);
        return dw + rw + ow;
    endfunction
    function automatic int off_ts(int dw, int rw, int ow, int pw);
        return dw + rw + ow + pw;
    endfunction
    function automatic int entry_w(int dw, int rw, int ow, int pw, int tw);
        return dw + rw + ow + pw + tw;
    endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port RAM, one write port and one registered read port
// Ports: clk, reset (clears read register), we/waddr/wdata write, re/raddr read, rdata registered output
module trace_ram #(
    parameter int W = 8,
    parameter int D = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [$clog2(D)-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic                 re,
    input  logic [$clog2(D)-1:0] raddr,
    output logic [W-1:0]         rdata
);
    logic [W-1:0] mem [D];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge clk)
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: circular writeback trace with PC trigger, post-trigger window and freeze-and-drain readout
// Inputs: clk, reset, arm, halt, trig_en/trig_pc, wb_valid/wb_pc/wb_opc/wb_rd/wb_data, rd_en
// Outputs: rd_valid, rd_pc/rd_opc/rd_rd/rd_data/rd_ts, count, overflow, state_o
// Optional: define TRACE_TIMESTAMP_EN to store a cycle timestamp with each entry
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 12,
    parameter int OPC_W    = 5,
    parameter int REG_W    = 5,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8,
    parameter int TS_W     = TS_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     halt,
    input  logic                     trig_en,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic                     wb_valid,
    input  logic [PC_W-1:0]          wb_pc,
    input  logic [OPC_W-1:0]         wb_opc,
    input  logic [REG_W-1:0]         wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [PC_W-1:0]          rd_pc,
    output logic [OPC_W-1:0]         rd_opc,
    output logic [REG_W-1:0]         rd_rd,
    output logic [DATA_W-1:0]        rd_data,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [2:0]               state_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int O_RD  = off_rd(DATA_W);
    localparam int O_OPC = off_opc(DATA_W, REG_W);
    localparam int O_PC  = off_pc(DATA_W, REG_W, OPC_W);
`ifdef TRACE_TIMESTAMP_EN
    localparam int O_TS  = off_ts(DATA_W, REG_W, OPC_W, PC_W);
    localparam int EW    = entry_w(DATA_W, REG_W, OPC_W, PC_W, TS_W);
`else
    localparam int EW    = entry_w(DATA_W, REG_W, OPC_W, PC_W, 0);
`endif
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PM1  = (AW + 1)'(POST_CNT - 1);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    state_t state, state_n;
    logic [AW-1:0] wp, rp;
    logic [AW:0] remaining;
    logic active, rec, fire, rd_acc;
    logic [EW-1:0] wdata, q;

    always_comb begin
        active  = state == ARMED || state == POST;
        rec     = active && wb_valid && !arm && !halt;
        fire    = rec && state == ARMED && trig_en && wb_pc == trig_pc;
        rd_acc  = state == FROZEN && rd_en && count != '0 && !arm;
        state_n = arm ? ARMED :
                  (halt && active) ? FROZEN :
                  fire ? (POST_CNT == 1 ? FROZEN : POST) :
                  (state == POST && rec && remaining == ONE) ? FROZEN : state;
    end

    always_ff @(posedge clk)
        if (reset) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            remaining <= '0;
        end else begin
            state    <= state_n;
            rd_valid <= rd_acc;
            if (arm) begin
                wp        <= '0;
                rp        <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                remaining <= '0;
            end else begin
                if (rec) begin
                    wp <= wp + 1'b1;
                    // Full buffer: the oldest entry is overwritten, so the read pointer follows
                    if (count == FULL) begin
                        rp       <= rp + 1'b1;
                        overflow <= 1'b1;
                    end else count <= count + 1'b1;
                end
                if (fire) remaining <= PM1;
                else if (state == POST && rec) remaining <= remaining - 1'b1;
                if (rd_acc) begin
                    rp    <= rp + 1'b1;
                    count <= count - 1'b1;
                end
            end
        end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    always_ff @(posedge clk)
        if (reset || arm) ts <= '0;
        else ts <= ts + 1'b1;
    assign wdata = {ts, wb_pc, wb_opc, wb_rd, wb_data};
    assign rd_ts = q[O_TS +: TS_W];
`else
    assign wdata = {wb_pc, wb_opc, wb_rd, wb_data};
    assign rd_ts = '0;
`endif

    trace_ram #(.W(EW), .D(DEPTH)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (rec),
        .waddr (wp),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rp),
        .rdata (q)
    );

    assign rd_pc   = q[O_PC +: PC_W];
    assign rd_opc  = q[O_OPC +: OPC_W];
    assign rd_rd   = q[O_RD +: REG_W];
    assign rd_data = q[OFF_DATA +: DATA_W];
    assign state_o = state;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed plus randomized check of commit_trace_buffer against a queue-based model
module tb_commit_trace_buffer;
    logic clk = 0, reset = 0, arm = 0, halt = 0, trig_en = 0, wb_valid = 0, rd_en = 0;
    logic [11:0] trig_pc = 0, wb_pc = 0;
    logic [4:0] wb_opc = 0, wb_rd = 0;
    logic [31:0] wb_data = 0;
    logic rd_valid, overflow;
    logic [11:0] rd_pc;
    logic [4:0] rd_opc, rd_rd;
    logic [31:0] rd_data;
    logic [15:0] rd_ts;
    logic [4:0] count;
    logic [2:0] state_o;

    commit_trace_buffer dut (
        .clk(clk), .reset(reset), .arm(arm), .halt(halt), .trig_en(trig_en), .trig_pc(trig_pc),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_opc(wb_opc), .wb_rd(wb_rd), .wb_data(wb_data),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_opc(rd_opc), .rd_rd(rd_rd),
        .rd_data(rd_data), .rd_ts(rd_ts), .count(count), .overflow(overflow), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pc;
        logic [4:0]  opc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] ts;
    } ent_t;

    ent_t buf_q[$];
    ent_t last;
    int m_state = 0, m_rem = 0, errors = 0, checks = 0;
    bit m_ovf = 0, m_valid = 0;
    logic [15:0] m_ts = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: buffer is a queue of committed entries, oldest at the front
    task automatic model_edge();
        ent_t e;
        logic [15:0] ts_now = m_ts;
        m_ts = (reset || arm) ? 16'd0 : m_ts + 16'd1;
        m_valid = 0;
        if (reset) begin
            m_state = 0; buf_q.delete(); m_ovf = 0; m_rem = 0;
            last = '{default: '0};
        end else if (arm) begin
            m_state = 1; buf_q.delete(); m_ovf = 0;
        end else if (halt && (m_state == 1 || m_state == 2)) begin
            m_state = 3;
        end else if ((m_state == 1 || m_state == 2) && wb_valid) begin
            e = '{wb_pc, wb_opc, wb_rd, wb_data, ts_now};
            buf_q.push_back(e);
            if (buf_q.size() > 16) begin
                void'(buf_q.pop_front());
                m_ovf = 1;
            end
            if (m_state == 1 && trig_en && wb_pc == trig_pc) begin
                m_rem = 7;
                m_state = 2;
            end else if (m_state == 2) begin
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
        end else if (m_state == 3 && rd_en && buf_q.size() > 0) begin
            last = buf_q.pop_front();
            m_valid = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("state", 64'(state_o), 64'(m_state));
        check("count", 64'(count), 64'(buf_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("rd_valid", 64'(rd_valid), 64'(m_valid));
        check("rd_pc", 64'(rd_pc), 64'(last.pc));
        check("rd_opc", 64'(rd_opc), 64'(last.opc));
        check("rd_rd", 64'(rd_rd), 64'(last.rd));
        check("rd_data", 64'(rd_data), 64'(last.data));
`ifdef TRACE_TIMESTAMP_EN
        check("rd_ts", 64'(rd_ts), 64'(last.ts));
`else
        check("rd_ts", 64'(rd_ts), 64'd0);
`endif
    endtask

    task automatic cyc(input bit r, input bit a, input bit h, input bit v, input int pc, input bit re);
        reset = r; arm = a; halt = h; wb_valid = v; wb_pc = 12'(pc); rd_en = re;
        wb_opc = 5'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
        step();
    endtask

    initial begin
        last = '{default: '0};
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        // Five entries, halt, drain plus one empty read
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, i, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("t1_count", 64'(count), 64'd5);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        // Overflow: 20 writes into 16 entries
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, i, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("t2_count", 64'(count), 64'd16);
        check("t2_overflow", 64'(overflow), 64'd1);
        cyc(0, 0, 0, 0, 0, 1);
        #3 check("t2_first_pc", 64'(rd_pc), 64'd4);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 1);
        // Trigger at pc 10 with 8-entry post window
        trig_en = 1; trig_pc = 12'd10;
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i <= 30; i++) cyc(0, 0, 0, 1, i, 0);
        check("t3_frozen", 64'(state_o), 64'd3);
        cyc(0, 0, 0, 0, 0, 1);
        #3 check("t3_first_pc", 64'(rd_pc), 64'd2);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 1);
        // halt beats a matching trigger; arm beats halt
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0);
        cyc(0, 0, 1, 1, 10, 0);
        check("t4_count", 64'(count), 64'd1);
        cyc(0, 1, 1, 0, 0, 0);
        check("t4_armed", 64'(state_o), 64'd1);
        // Reset in POST with 7 entries
        trig_pc = 12'd0;
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, i, 0);
        check("t5_post", 64'(state_o), 64'd2);
        cyc(1, 0, 0, 0, 0, 0);
        check("t5_idle_count", 64'(count), 64'd0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // Timestamps: writebacks 3, 4 and 9 cycles after arm
        trig_en = 0;
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, (i == 3 || i == 4 || i == 9), 100 + i, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                trig_en = 1'($urandom);
                trig_pc = 12'($urandom_range(0, 31));
            end
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0,
                1'($urandom), $urandom_range(0, 31), $urandom_range(0, 3) != 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable writeback-trace capture unit attached to the processor's writeback stage.
- Records committed instructions (PC, opcode, destination register, write data) into a circular buffer.
- Supports pre-trigger history, a PC-match trigger with a post-trigger window, and a freeze-and-drain readout port.
- Replaces per-cycle simulation printing, so traces are available on hardware and in long simulations.

Parameters:
- DATA_W, 32: width of writeback data.
- PC_W, 12: width of the instruction-memory address.
- OPC_W, 5: opcode field width.
- REG_W, 5: register index width.
- DEPTH, 16: number of buffer entries; power of 2, at least 2.
- POST_CNT, 8: entries recorded from the trigger entry onward, including the trigger entry; range 1..DEPTH.
- TS_W, 16: timestamp width; used only with the optional feature.

Ports:
- clk  in  1  Single clock. All logic updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- arm  in  1  Pulse: clears the buffer and enters ARMED.
- halt  in  1  Pulse: force-freezes the buffer from ARMED or POST.
- trig_en  in  1  Enables PC-match triggering.
- trig_pc  in  PC_W  Trigger PC.
- wb_valid  in  1  A committed writeback is present this cycle.
- wb_pc  in  PC_W  PC of the committing instruction.
- wb_opc  in  OPC_W  Opcode of the committing instruction.
- wb_rd  in  REG_W  Destination register.
- wb_data  in  DATA_W  Written value.
- rd_en  in  1  Read request; pops the oldest entry.
- rd_valid  out  1  Read data valid.
- rd_pc  out  PC_W  Read PC field.
- rd_opc  out  OPC_W  Read opcode field.
- rd_rd  out  REG_W  Read destination-register field.
- rd_data  out  DATA_W  Read data field.
- rd_ts  out  TS_W  Read timestamp field.
- count  out  clog2(DEPTH)+1  Number of valid entries.
- overflow  out  1  Sticky: an entry was overwritten.
- state_o  out  3  Current state encoding.

Behaviour:
- States and encodings: IDLE=0, ARMED=1, POST=2, FROZEN=3.
- Reset:
  - State goes to IDLE; write and read pointers go to 0.
  - count=0, overflow=0, rd_valid=0.
  - All rd_* fields go to 0; post counter goes to 0.
  - Buffer RAM contents are don't-care.
- Priority, highest first: reset, arm, halt, trigger, record.
- arm, in any state:
  - Next state is ARMED.
  - Pointers, count, overflow and rd_valid are cleared.
  - A wb_valid in the same cycle is not recorded.
- Recording happens in ARMED and POST when wb_valid=1:
  - Write {pc, opc, rd, data[, ts]} at the write pointer; the write pointer increments modulo DEPTH.
  - If count<DEPTH, count increments.
  - If count==DEPTH, the oldest entry is overwritten, the read pointer advances with the write pointer, count is held, and overflow is set.
- Trigger:
  - Fires in ARMED when trig_en, wb_valid and wb_pc==trig_pc are all true.
  - The trigger entry is recorded.
  - If POST_CNT==1, next state is FROZEN; otherwise next state is POST with remaining=POST_CNT-1.
- POST:
  - Each recorded entry decrements remaining.
  - When a recording makes remaining reach 0, next state is FROZEN.
  - A PC match in POST is ignored.
- halt:
  - In ARMED or POST, next state is FROZEN; an entry in the same cycle is not recorded.
  - halt is ignored in IDLE and FROZEN.
- FROZEN:
  - No recording.
  - rd_en with count>0: read the entry at the read pointer; the fields appear with rd_valid=1 on the next cycle (latency 1). The read pointer increments and count decrements.
  - rd_en with count==0: rd_valid=0 next cycle; no pointer change.
  - Back-to-back rd_en is allowed, one entry per cycle.
  - rd_valid is a single-cycle pulse per accepted read; rd_* fields hold their last value otherwise.
- rd_en outside FROZEN is ignored (rd_valid=0).
- FROZEN leaves only on arm or reset.
- Readout order is oldest first; wrap-around is handled by pointer modulo DEPTH.
- Buffer: inferred simple dual-port RAM with a registered read.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W-bit cycle counter is cleared by reset and by arm, and wraps at 2^TS_W.
  - Its value at the recording cycle is stored with each entry and returned on rd_ts.
- Undefined:
  - No counter and no timestamp storage.
  - rd_ts is tied to 0.

Decomposition:
- Shared package trace_pkg:
  - State encoding constants.
  - Entry field offsets and total entry width.
  - Timestamp width default.
- One natural sub-module: trace_ram (parametrised width/depth, one write port, one registered read port).
- Control, pointers and counters stay in the top module.

Test Plan:
1. Reset, then arm; 5 writebacks pc=1..5 in ARMED, then halt -> FROZEN, count=5. Five rd_en return pc 1..5 in order, each one cycle later; a 6th rd_en gives rd_valid=0.
2. DEPTH=16: arm, then 20 writebacks pc=0..19, then halt -> count=16, overflow=1, readout pc 4..19.
3. POST_CNT=8, trig_pc=10: writebacks pc=0..30 -> freezes after pc=17; with DEPTH=16, buffer holds pc 2..17.
4. Same cycle: halt and matching trigger with wb_valid -> FROZEN, trigger entry not recorded. Same cycle: arm and halt -> ARMED with count=0.
5. reset asserted in POST with count=7 -> next cycle IDLE, count=0, overflow=0, rd_valid=0. rd_en in IDLE -> no rd_valid.
6. With TRACE_TIMESTAMP_EN: arm at cycle 0, writebacks at cycles 3, 4 and 9 -> rd_ts=3, 4, 9. Without the macro -> rd_ts=0.
